// File: rtl/ctrl_sm_pkg.sv
// ctrl_sm_pkg: state, instruction-class and trap-cause codes shared by the control FSM and its bus.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package ctrl_sm_pkg;

    typedef enum logic [2:0] {
        STATE_START = 3'd0,
        STATE_FETCH = 3'd1,
        STATE_LOAD  = 3'd2,
        STATE_STORE = 3'd3,
        STATE_EXEC  = 3'd4,
        STATE_HALT  = 3'd5,
        STATE_TRAP  = 3'd6
    } state_t;

    typedef logic [3:0] inst_t;
    typedef logic [1:0] cause_t;

    // Any code not listed here decodes as an ALU-class instruction.
    localparam inst_t INST_LOAD_BYTE = 4'd1;
    localparam inst_t INST_LOAD_HALF = 4'd2;
    localparam inst_t INST_LOAD_WORD = 4'd3;
    localparam inst_t INST_STORE     = 4'd4;
    localparam inst_t INST_EBREAK    = 4'd5;

    localparam cause_t TRAP_NONE   = 2'd0;
    localparam cause_t TRAP_IFU_TO = 2'd1;
    localparam cause_t TRAP_LSU_TO = 2'd2;

    function automatic logic is_load(input inst_t inst);
        return (inst == INST_LOAD_BYTE) || (inst == INST_LOAD_HALF) || (inst == INST_LOAD_WORD);
    endfunction

endpackage

// File: rtl/ctrl_sm_if.sv
// ctrl_sm_if: IFU/LSU handshakes, debug controls and datapath enables around the control FSM.
// Latency: none (wires only).
// Backpressure: none; responses are single-cycle pulses the FSM must not miss.
interface ctrl_sm_if;
    import ctrl_sm_pkg::*;

    logic   ifu_respValid;
    logic   lsu_respValid;
    inst_t  inst_type;
    logic   halt_req;
    logic   resume;
    logic   reg_wen;
    logic   pc_wen;
    logic   lsu_wen;
    logic   lsu_reqValid;
    logic   ifu_reqValid;
    logic   halted;
    logic   trap;
    cause_t trap_cause;

    modport master (
        input  ifu_respValid, lsu_respValid, inst_type, halt_req, resume,
        output reg_wen, pc_wen, lsu_wen, lsu_reqValid, ifu_reqValid, halted, trap, trap_cause
    );

    modport slave (
        output ifu_respValid, lsu_respValid, inst_type, halt_req, resume,
        input  reg_wen, pc_wen, lsu_wen, lsu_reqValid, ifu_reqValid, halted, trap, trap_cause
    );

endinterface

// File: rtl/wait_timer.sv
// wait_timer: counts cycles spent waiting for a bus response and flags the last allowed one.
// Latency: expired is combinational from the count and enable in the timeout cycle.
// Backpressure: none; a response (enable low) in the timeout cycle suppresses expired.
module wait_timer #(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            // The count is cleared on entry to a wait, so the Nth waiting cycle sees N-1.
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

            logic [CNT_W-1:0] count;

            // Wait-cycle counter: clear has priority over counting.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (enable) begin
                    count <= count + CNT_W'(1);
                end
            end

            assign expired = enable && (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/ctrl_sm.sv
// ctrl_sm: multi-cycle CPU control FSM with power-on hold-off, bus watchdog and debug halt.
// Latency: Mealy outputs in the response cycle; next fetch one cycle after an ALU/load retire.
// Backpressure: waits indefinitely on IFU/LSU responses unless the watchdog traps.
module ctrl_sm
    import ctrl_sm_pkg::*;
#(
    parameter int START_CYCLES   = 10,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic      clock,
    input  logic      reset,
    ctrl_sm_if.master bus
);

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] start_cnt;
    cause_t           cause_q;
    cause_t           cause_next;
    logic             at_boundary;
    logic             wait_clear;
    logic             wait_enable;
    logic             wait_expired;

    // A waiting cycle is one in FETCH/LOAD/STORE without the matching response.
    assign wait_enable = ((state == STATE_FETCH) && !bus.ifu_respValid) ||
                         (((state == STATE_LOAD) || (state == STATE_STORE)) && !bus.lsu_respValid);
    // Every state change restarts the wait count, which covers entry to each waiting state.
    assign wait_clear  = (state_next != state);

    wait_timer #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (wait_clear),
        .enable  (wait_enable),
        .expired (wait_expired)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= STATE_START;
        end else begin
            state <= state_next;
        end
    end

    // Power-on hold-off counter; parks once the first fetch is due.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_cnt <= '0;
        end else if ((state == STATE_START) && (start_cnt != START_LAST)) begin
            start_cnt <= start_cnt + CNT_W'(1);
        end
    end

    // Trap cause is sticky until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cause_q <= TRAP_NONE;
        end else begin
            cause_q <= cause_next;
        end
    end

    assign bus.trap_cause = cause_q;

    // Next-state and Mealy outputs; everything reads 0 while reset is held.
    always_comb begin
        state_next       = state;
        cause_next       = cause_q;
        at_boundary      = 1'b0;
        bus.reg_wen      = 1'b0;
        bus.pc_wen       = 1'b0;
        bus.lsu_wen      = 1'b0;
        bus.lsu_reqValid = 1'b0;
        bus.ifu_reqValid = 1'b0;
        bus.halted       = 1'b0;
        bus.trap         = 1'b0;
        if (!reset) begin
            case (state)
                STATE_START: begin
                    if (start_cnt == START_LAST) begin
                        bus.ifu_reqValid = 1'b1;
                        state_next       = STATE_FETCH;
                    end
                end
                STATE_FETCH: begin
                    if (bus.ifu_respValid) begin
                        if (bus.inst_type == INST_EBREAK) begin
                            state_next = STATE_HALT;
                        end else begin
                            bus.pc_wen = 1'b1;
                            if (is_load(bus.inst_type)) begin
                                bus.lsu_reqValid = 1'b1;
                                state_next       = STATE_LOAD;
                            end else if (bus.inst_type == INST_STORE) begin
                                bus.lsu_reqValid = 1'b1;
                                bus.lsu_wen      = 1'b1;
                                state_next       = STATE_STORE;
                            end else begin
                                bus.reg_wen = 1'b1;
                                state_next  = STATE_EXEC;
                            end
                        end
                    end else if (wait_expired) begin
                        state_next = STATE_TRAP;
                        cause_next = TRAP_IFU_TO;
                    end
                end
                STATE_LOAD: begin
                    if (bus.lsu_respValid) begin
                        bus.reg_wen = 1'b1;
                        state_next  = STATE_EXEC;
                    end else if (wait_expired) begin
                        state_next = STATE_TRAP;
                        cause_next = TRAP_LSU_TO;
                    end
                end
                STATE_STORE: begin
                    if (bus.lsu_respValid) begin
                        at_boundary = 1'b1;
                    end else if (wait_expired) begin
                        state_next = STATE_TRAP;
                        cause_next = TRAP_LSU_TO;
                    end
                end
                STATE_HALT: begin
                    bus.halted = 1'b1;
                    if (bus.resume) begin
                        bus.ifu_reqValid = 1'b1;
                        state_next       = STATE_FETCH;
                    end
                end
                STATE_TRAP: begin
                    bus.trap = 1'b1;
                end
                // EXEC, and the unused encoding, retire the instruction.
                default: begin
                    at_boundary = 1'b1;
                end
            endcase
            // Instruction boundary: a pending halt request wins over the next fetch.
            if (at_boundary) begin
                if (bus.halt_req) begin
                    state_next = STATE_HALT;
                end else begin
                    bus.ifu_reqValid = 1'b1;
                    state_next       = STATE_FETCH;
                end
            end
        end
    end

    logic [39:0] state_name_unused;

    // ASCII state name for waveform viewing.
    always_comb begin
        case (state)
            STATE_START: state_name_unused = "START";
            STATE_FETCH: state_name_unused = "FETCH";
            STATE_LOAD:  state_name_unused = "LOAD ";
            STATE_STORE: state_name_unused = "STORE";
            STATE_EXEC:  state_name_unused = "EXEC ";
            STATE_HALT:  state_name_unused = "HALT ";
            STATE_TRAP:  state_name_unused = "TRAP ";
            default:     state_name_unused = "EXEC ";
        endcase
    end

endmodule

// File: tb/tb_ctrl_sm.sv
// tb_ctrl_sm: directed vector table, watchdog/debug sequences and randomized traffic against a model.
// Latency: inputs driven at the falling edge, outputs sampled 1 time unit later.
// Backpressure: responses are randomized pulses; the model decides when the watchdog must fire.
module tb_ctrl_sm;
    import ctrl_sm_pkg::*;

    localparam int START_N   = 10;
    localparam int TIMEOUT_N = 4;

    // Output vector bit positions: {reg pc lsu_wen lsu_req ifu_req halted trap cause[1:0]}.
    localparam logic [8:0] O_NONE  = 9'h000;
    localparam logic [8:0] O_REG   = 9'h100;
    localparam logic [8:0] O_PC    = 9'h080;
    localparam logic [8:0] O_LW    = 9'h040;
    localparam logic [8:0] O_LREQ  = 9'h020;
    localparam logic [8:0] O_IREQ  = 9'h010;
    localparam logic [8:0] O_HLT   = 9'h008;
    localparam logic [8:0] O_TRAP  = 9'h004;
    localparam logic [8:0] O_C_IFU = 9'h001;
    localparam logic [8:0] O_C_LSU = 9'h002;

    // Code 0 is not a load, store or ebreak, so it decodes as an ALU op (ADD).
    localparam logic [3:0] I_ADD = 4'd0;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ctrl_sm_if bus();

    ctrl_sm #(
        .START_CYCLES   (START_N),
        .TIMEOUT_CYCLES (TIMEOUT_N),
        .CNT_W          (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       ifu_r;
        logic       lsu_r;
        logic [3:0] inst;
        logic       halt;
        logic       res;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Reference model: what the core is waiting on, how long it has waited, debug/dead flags.
    localparam int W_NONE  = 0;
    localparam int W_IFU   = 1;
    localparam int W_LOAD  = 2;
    localparam int W_STORE = 3;

    bit         m_booting;
    int         m_boot;
    int         m_wait;
    int         m_waited;
    bit         m_debug;
    bit         m_dead;
    logic [1:0] m_cause;

    function automatic logic [8:0] outs();
        return {bus.reg_wen, bus.pc_wen, bus.lsu_wen, bus.lsu_reqValid, bus.ifu_reqValid,
                bus.halted, bus.trap, bus.trap_cause};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: {reg pc lsu_wen lsu_req ifu_req halted trap cause}=%b, required %b",
                     name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic lr, input logic [3:0] it,
                         input logic hr, input logic rs);
        bus.ifu_respValid = ir;
        bus.lsu_respValid = lr;
        bus.inst_type     = it;
        bus.halt_req      = hr;
        bus.resume        = rs;
    endtask

    // One cycle: drive at the falling edge, sample before the rising edge, move to next falling edge.
    task automatic step(input string name, input logic ir, input logic lr, input logic [3:0] it,
                        input logic hr, input logic rs, input logic [8:0] exp);
        drive(ir, lr, it, hr, rs);
        #1;
        check(name, outs(), exp);
        @(negedge clock);
    endtask

    // Asynchronous reset mid-cycle with arbitrary inputs; outputs must all read 0 while it is high.
    task automatic apply_reset(input string name);
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        #2 reset = 1'b1;
        #1 check(name, outs(), O_NONE);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic boot_check(input string tag);
        for (int c = 0; c <= START_N; c++) begin
            step($sformatf("%s_c%0d", tag, c), 1'b0, 1'b0, I_ADD, 1'b0, 1'b0,
                 (c == START_N) ? O_IREQ : O_NONE);
        end
    endtask

    task automatic model_reset();
        m_booting = 1'b1;
        m_boot    = 0;
        m_wait    = W_NONE;
        m_waited  = 0;
        m_debug   = 1'b0;
        m_dead    = 1'b0;
        m_cause   = 2'd0;
    endtask

    task automatic model_step(input logic ir, input logic lr, input logic [3:0] it,
                              input logic hr, input logic rs, output logic [8:0] e);
        logic got;
        logic retire;
        e      = {7'd0, m_cause};
        retire = 1'b0;
        if (m_dead) begin
            e |= O_TRAP;
        end else if (m_debug) begin
            e |= O_HLT;
            if (rs) begin
                e |= O_IREQ;
                m_debug  = 1'b0;
                m_wait   = W_IFU;
                m_waited = 0;
            end
        end else if (m_booting) begin
            if (m_boot == START_N) begin
                e |= O_IREQ;
                m_booting = 1'b0;
                m_wait    = W_IFU;
                m_waited  = 0;
            end else begin
                m_boot++;
            end
        end else if (m_wait != W_NONE) begin
            m_waited++;
            got = (m_wait == W_IFU) ? ir : lr;
            if (got) begin
                if (m_wait == W_IFU) begin
                    if (it == INST_EBREAK) begin
                        m_debug = 1'b1;
                    end else if (it == INST_LOAD_BYTE || it == INST_LOAD_HALF || it == INST_LOAD_WORD) begin
                        e |= O_PC | O_LREQ;
                        m_wait   = W_LOAD;
                        m_waited = 0;
                    end else if (it == INST_STORE) begin
                        e |= O_PC | O_LREQ | O_LW;
                        m_wait   = W_STORE;
                        m_waited = 0;
                    end else begin
                        e |= O_PC | O_REG;
                        m_wait = W_NONE;
                    end
                end else if (m_wait == W_LOAD) begin
                    e |= O_REG;
                    m_wait = W_NONE;
                end else begin
                    retire = 1'b1;
                end
            end else if (m_waited == TIMEOUT_N) begin
                m_dead  = 1'b1;
                m_cause = (m_wait == W_IFU) ? 2'd1 : 2'd2;
            end
        end else begin
            retire = 1'b1;
        end
        if (retire) begin
            if (hr) begin
                m_debug = 1'b1;
            end else begin
                e |= O_IREQ;
                m_wait   = W_IFU;
                m_waited = 0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "bench time limit expired");
    end

    initial begin
        logic       ir, lr, hr, rs;
        logic [3:0] it;
        logic [8:0] e;

        // {ifu_resp, lsu_resp, inst, halt_req, resume, expected outputs}, starting in FETCH.
        tbl.push_back(vec_t'{1'b1, 1'b0, I_ADD,          1'b0, 1'b0, O_REG | O_PC});
        tbl.push_back(vec_t'{1'b0, 1'b0, I_ADD,          1'b0, 1'b0, O_IREQ});
        tbl.push_back(vec_t'{1'b1, 1'b0, INST_LOAD_WORD, 1'b0, 1'b0, O_PC | O_LREQ});
        tbl.push_back(vec_t'{1'b0, 1'b0, I_ADD,          1'b0, 1'b0, O_NONE});
        tbl.push_back(vec_t'{1'b1, 1'b0, I_ADD,          1'b0, 1'b0, O_NONE});
        tbl.push_back(vec_t'{1'b0, 1'b1, I_ADD,          1'b0, 1'b0, O_REG});
        tbl.push_back(vec_t'{1'b0, 1'b0, I_ADD,          1'b0, 1'b0, O_IREQ});
        tbl.push_back(vec_t'{1'b1, 1'b0, INST_STORE,     1'b0, 1'b0, O_PC | O_LW | O_LREQ});
        tbl.push_back(vec_t'{1'b0, 1'b0, I_ADD,          1'b0, 1'b0, O_NONE});
        tbl.push_back(vec_t'{1'b0, 1'b1, I_ADD,          1'b0, 1'b0, O_IREQ});
        tbl.push_back(vec_t'{1'b1, 1'b0, INST_EBREAK,    1'b0, 1'b0, O_NONE});
        tbl.push_back(vec_t'{1'b0, 1'b1, I_ADD,          1'b0, 1'b0, O_HLT});
        tbl.push_back(vec_t'{1'b0, 1'b0, I_ADD,          1'b0, 1'b1, O_HLT | O_IREQ});
        tbl.push_back(vec_t'{1'b1, 1'b0, I_ADD,          1'b1, 1'b0, O_REG | O_PC});
        tbl.push_back(vec_t'{1'b0, 1'b0, I_ADD,          1'b1, 1'b0, O_NONE});
        tbl.push_back(vec_t'{1'b0, 1'b0, I_ADD,          1'b1, 1'b0, O_HLT});
        tbl.push_back(vec_t'{1'b0, 1'b0, I_ADD,          1'b1, 1'b1, O_HLT | O_IREQ});
        tbl.push_back(vec_t'{1'b1, 1'b0, INST_LOAD_BYTE, 1'b1, 1'b0, O_PC | O_LREQ});
        tbl.push_back(vec_t'{1'b0, 1'b1, I_ADD,          1'b1, 1'b0, O_REG});
        tbl.push_back(vec_t'{1'b0, 1'b0, I_ADD,          1'b1, 1'b0, O_NONE});
        tbl.push_back(vec_t'{1'b0, 1'b0, I_ADD,          1'b0, 1'b0, O_HLT});
        tbl.push_back(vec_t'{1'b0, 1'b0, I_ADD,          1'b0, 1'b1, O_HLT | O_IREQ});
        tbl.push_back(vec_t'{1'b0, 1'b1, I_ADD,          1'b0, 1'b0, O_NONE});
        tbl.push_back(vec_t'{1'b1, 1'b0, I_ADD,          1'b0, 1'b0, O_REG | O_PC});
        tbl.push_back(vec_t'{1'b1, 1'b0, I_ADD,          1'b0, 1'b0, O_IREQ});

        drive(1'b0, 1'b0, I_ADD, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        drive(1'b1, 1'b1, INST_STORE, 1'b1, 1'b1);
        #1 check("reset_hold", outs(), O_NONE);
        @(negedge clock);
        drive(1'b0, 1'b0, I_ADD, 1'b0, 1'b0);
        reset = 1'b0;

        boot_check("boot");

        foreach (tbl[i]) begin
            step($sformatf("vec%0d", i), tbl[i].ifu_r, tbl[i].lsu_r, tbl[i].inst,
                 tbl[i].halt, tbl[i].res, tbl[i].exp);
        end

        // IFU hang: the last table row issued a fetch request.
        for (int k = 1; k <= TIMEOUT_N; k++) begin
            step($sformatf("ifu_wait%0d", k), 1'b0, 1'b0, I_ADD, 1'b0, 1'b0, O_NONE);
        end
        step("ifu_trap", 1'b0, 1'b0, I_ADD, 1'b0, 1'b0, O_TRAP | O_C_IFU);
        step("trap_sticky", 1'b1, 1'b1, I_ADD, 1'b0, 1'b1, O_TRAP | O_C_IFU);
        apply_reset("trap_reset");
        boot_check("reboot");

        // Response in the timeout cycle wins.
        for (int k = 1; k < TIMEOUT_N; k++) begin
            step($sformatf("late_wait%0d", k), 1'b0, 1'b0, I_ADD, 1'b0, 1'b0, O_NONE);
        end
        step("ifu_resp_last_cycle", 1'b1, 1'b0, I_ADD, 1'b0, 1'b0, O_REG | O_PC);
        step("after_last_cycle", 1'b0, 1'b0, I_ADD, 1'b0, 1'b0, O_IREQ);

        // LSU hang on a load.
        step("load_issue", 1'b1, 1'b0, INST_LOAD_HALF, 1'b0, 1'b0, O_PC | O_LREQ);
        for (int k = 1; k <= TIMEOUT_N; k++) begin
            step($sformatf("lsu_wait%0d", k), 1'b0, 1'b0, I_ADD, 1'b0, 1'b0, O_NONE);
        end
        step("lsu_trap", 1'b0, 1'b0, I_ADD, 1'b0, 1'b0, O_TRAP | O_C_LSU);

        // Randomized traffic, each round starting with a reset mid-transaction.
        for (int r = 0; r < 10; r++) begin
            apply_reset($sformatf("rand_reset%0d", r));
            model_reset();
            for (int n = 0; n < 200; n++) begin
                ir = ($urandom_range(0, 99) < 70);
                lr = ($urandom_range(0, 99) < 70);
                it = 4'($urandom_range(0, 7));
                hr = ($urandom_range(0, 99) < 25);
                rs = ($urandom_range(0, 99) < 30);
                model_step(ir, lr, it, hr, rs, e);
                step($sformatf("rand%0d_%0d", r, n), ir, lr, it, hr, rs, e);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
